// File: rtl/ram_store_controller.sv
// ram_store_controller: buffers execute-stage stores/pokes in an in-order FIFO and
// retires one write per cycle to variable RAM or, via a fetch stall/idle
// handshake, to program RAM.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   in_valid/in_ready               request handshake (push on both high)
//   in_target/in_addr/in_data       0 = variable RAM store, 1 = program RAM poke
//   fetch_idle                      fetch confirms no program-RAM access this cycle
//   p_ram_stall                     asks fetch to halt while a poke is pending
//   p_ram_we/p_ram_addr/p_ram_wdata program RAM write port (registered)
//   v_ram_we/v_ram_addr/v_ram_wdata variable RAM write port (registered)
//   pending                         FIFO non-empty, poke in progress or strobe high
//
// Optional STORE_STATS_EN adds saturating counters p_write_count,
// v_write_count and stall_cycles.
module ram_store_controller #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_target,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [WORD_SIZE-1:0]  in_data,
  input  logic                  fetch_idle,
  output logic                  p_ram_stall,
  output logic                  p_ram_we,
  output logic [ADDR_WIDTH-1:0] p_ram_addr,
  output logic [WORD_SIZE-1:0]  p_ram_wdata,
  output logic                  v_ram_we,
  output logic [ADDR_WIDTH-1:0] v_ram_addr,
  output logic [WORD_SIZE-1:0]  v_ram_wdata,
  output logic                  pending
`ifdef STORE_STATS_EN
  ,
  output logic [15:0]           p_write_count,
  output logic [15:0]           v_write_count,
  output logic [15:0]           stall_cycles
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + ADDR_WIDTH + WORD_SIZE;
  typedef enum logic [1:0] {IDLE, P_REQ, P_WRITE} state_t;
  state_t                state_q, state_d;
  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  v_we_q, v_we_d, p_we_q, p_we_d, stall_q, stall_d;
  logic [ADDR_WIDTH-1:0] v_addr_q, v_addr_d, p_addr_q, p_addr_d;
  logic [WORD_SIZE-1:0]  v_data_q, v_data_d, p_data_q, p_data_d;
  logic [EW-1:0]         head;
  logic                  head_t, empty, push, pop;
  logic [ADDR_WIDTH-1:0] head_a;
  logic [WORD_SIZE-1:0]  head_d;
  assign head   = mem_q[rd_ptr_q];
  assign head_t = head[EW-1];
  assign head_a = head[EW-2:WORD_SIZE];
  assign head_d = head[WORD_SIZE-1:0];
  assign empty  = count_q == '0;
  // in_ready comes from registered occupancy only, so a same-cycle pop never frees a slot early
  assign in_ready = count_q < CW'(FIFO_DEPTH);
  assign push     = in_valid && in_ready;
  // a program-RAM head is only popped once fetch has gone idle, blocking everything behind it
  assign pop = (state_q == IDLE && !empty && !head_t) || (state_q == P_REQ && fetch_idle);
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_target, in_addr, in_data};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      v_we_q   <= 1'b0;
      v_addr_q <= '0;
      v_data_q <= '0;
      p_we_q   <= 1'b0;
      p_addr_q <= '0;
      p_data_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      v_we_q   <= v_we_d;
      v_addr_q <= v_addr_d;
      v_data_q <= v_data_d;
      p_we_q   <= p_we_d;
      p_addr_q <= p_addr_d;
      p_data_q <= p_data_d;
      stall_q  <= stall_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE  ? ((!empty && head_t) ? P_REQ : IDLE) :
              state_q == P_REQ ? (fetch_idle ? P_WRITE : P_REQ) : IDLE;
  end
  // stall covers the whole request/write window and drops as the FSM returns to IDLE
  always_comb begin
    v_we_d   = state_q == IDLE && !empty && !head_t;
    v_addr_d = v_we_d ? head_a : v_addr_q;
    v_data_d = v_we_d ? head_d : v_data_q;
    p_we_d   = state_q == P_REQ && fetch_idle;
    p_addr_d = p_we_d ? head_a : p_addr_q;
    p_data_d = p_we_d ? head_d : p_data_q;
    stall_d  = state_d != IDLE;
  end
  assign v_ram_we    = v_we_q;
  assign v_ram_addr  = v_addr_q;
  assign v_ram_wdata = v_data_q;
  assign p_ram_we    = p_we_q;
  assign p_ram_addr  = p_addr_q;
  assign p_ram_wdata = p_data_q;
  assign p_ram_stall = stall_q;
  assign pending     = !empty || state_q != IDLE || v_we_q || p_we_q;
`ifdef STORE_STATS_EN
  logic [15:0] p_cnt_q, p_cnt_d, v_cnt_q, v_cnt_d, s_cnt_q, s_cnt_d;
  always_comb begin
    p_cnt_d = (p_we_q && p_cnt_q != 16'hFFFF) ? p_cnt_q + 16'd1 : p_cnt_q;
    v_cnt_d = (v_we_q && v_cnt_q != 16'hFFFF) ? v_cnt_q + 16'd1 : v_cnt_q;
    s_cnt_d = (state_q == P_REQ && !fetch_idle && s_cnt_q != 16'hFFFF) ? s_cnt_q + 16'd1 : s_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_cnt_q <= '0;
      v_cnt_q <= '0;
      s_cnt_q <= '0;
    end else begin
      p_cnt_q <= p_cnt_d;
      v_cnt_q <= v_cnt_d;
      s_cnt_q <= s_cnt_d;
    end
  end
  assign p_write_count = p_cnt_q;
  assign v_write_count = v_cnt_q;
  assign stall_cycles  = s_cnt_q;
`endif
endmodule

// File: tb/tb_ram_store_controller.sv
// tb_ram_store_controller: directed and randomized checks against a queue-based reference model
module tb_ram_store_controller;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_target, fetch_idle;
  logic [7:0]  in_addr, p_ram_addr, v_ram_addr;
  logic [15:0] in_data, p_ram_wdata, v_ram_wdata;
  logic        p_ram_stall, p_ram_we, v_ram_we, pending;
`ifdef STORE_STATS_EN
  logic [15:0] p_write_count, v_write_count, stall_cycles;
`endif
  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int both_hi = 0;
  int p_bad = 0;
  logic fi_s = 1'b0;
  logic stop = 1'b0;
  typedef struct packed {logic t; logic [7:0] a; logic [15:0] d; int c;} wr_t;
  wr_t obs[$];
  wr_t exp_q[$];

  ram_store_controller dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_target(in_target), .in_addr(in_addr), .in_data(in_data),
    .fetch_idle(fetch_idle), .p_ram_stall(p_ram_stall), .p_ram_we(p_ram_we),
    .p_ram_addr(p_ram_addr), .p_ram_wdata(p_ram_wdata), .v_ram_we(v_ram_we),
    .v_ram_addr(v_ram_addr), .v_ram_wdata(v_ram_wdata), .pending(pending)
`ifdef STORE_STATS_EN
    , .p_write_count(p_write_count), .v_write_count(v_write_count), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    fi_s <= fetch_idle;
  end
  // observed write log, sampled shortly after each edge; cyc is the index of that edge
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (v_ram_we) obs.push_back(wr_t'{1'b0, v_ram_addr, v_ram_wdata, cyc});
      if (p_ram_we) begin
        obs.push_back(wr_t'{1'b1, p_ram_addr, p_ram_wdata, cyc});
        if (!fi_s || !p_ram_stall) p_bad++;
      end
      if (v_ram_we && p_ram_we) both_hi++;
    end
  end

  // starts and ends at a negedge; e is the edge index at which the request was accepted
  task automatic send(input logic t, input logic [7:0] a, input logic [15:0] d, output int e, output logic rdy);
    in_valid = 1'b1; in_target = t; in_addr = a; in_data = d;
    rdy = in_ready;
    e = -1;
    for (int i = 0; i < 300; i++) begin
      if (in_ready) begin
        @(negedge clk);
        e = cyc;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!pending) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_target = 1'b0; in_addr = '0; in_data = '0; fetch_idle = 1'b0;
    #12;
    checks++;
    if ({in_ready, pending, v_ram_we, p_ram_we, p_ram_stall, v_ram_addr, v_ram_wdata, p_ram_addr, p_ram_wdata} !== {1'b1, 52'd0})
      $display("FAIL reset_state: ready=%b pend=%b vwe=%b pwe=%b stall=%b va=%h vd=%h pa=%h pd=%h expected ready=1, rest 0",
               in_ready, pending, v_ram_we, p_ram_we, p_ram_stall, v_ram_addr, v_ram_wdata, p_ram_addr, p_ram_wdata);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_v();
    int e; logic r, ok;
    obs.delete();
    send(1'b0, 8'h12, 16'hBEEF, e, r);
    wait_idle(ok);
    checks++;
    if (!ok || obs.size() != 1) $display("FAIL single_v_count: idle=%b writes=%0d expected idle=1 writes=1", ok, obs.size());
    else passed++;
    checks++;
    if (obs[0] !== wr_t'{1'b0, 8'h12, 16'hBEEF, e + 1})
      $display("FAIL single_v_write: got t=%b a=%h d=%h edge=%0d expected t=0 a=12 d=beef edge=%0d", obs[0].t, obs[0].a, obs[0].d, obs[0].c, e + 1);
    else passed++;
    checks++;
    if ({v_ram_addr, v_ram_wdata, v_ram_we} !== {8'h12, 16'hBEEF, 1'b0})
      $display("FAIL single_v_hold: a=%h d=%h we=%b expected a=12 d=beef we=0", v_ram_addr, v_ram_wdata, v_ram_we);
    else passed++;
  endtask

  task automatic test_v_burst();
    int e[4]; logic r, rmin, ok;
    obs.delete();
    rmin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 8'(i), 16'h1000 + 16'(i), e[i], r);
      rmin &= r;
    end
    wait_idle(ok);
    checks++;
    if (!rmin || !ok || obs.size() != 4 || e[3] != e[0] + 3)
      $display("FAIL burst_flow: ready_all=%b idle=%b writes=%0d span=%0d expected 1 1 4 3", rmin, ok, obs.size(), e[3] - e[0]);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs[i] !== wr_t'{1'b0, 8'(i), 16'h1000 + 16'(i), e[0] + 1 + i})
        $display("FAIL burst_write%0d: got a=%h d=%h edge=%0d expected a=%h d=%h edge=%0d",
                 i, obs[i].a, obs[i].d, obs[i].c, i, 16'h1000 + 16'(i), e[0] + 1 + i);
      else passed++;
    end
  endtask

  task automatic test_p_poke();
    int e, c; logic r, ok, stall_ok;
    obs.delete();
    fetch_idle = 1'b0;
    send(1'b1, 8'h40, 16'hA5A5, e, r);
    stall_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!p_ram_stall || p_ram_we) stall_ok = 1'b0;
    end
    checks++;
    if (!stall_ok) $display("FAIL poke_wait_stall: stall not held (or early we) while fetch busy, expected stall=1 we=0");
    else passed++;
    fetch_idle = 1'b1;
    c = cyc;
    @(negedge clk);
    checks++;
    if ({p_ram_we, p_ram_stall, p_ram_addr, p_ram_wdata} !== {1'b1, 1'b1, 8'h40, 16'hA5A5})
      $display("FAIL poke_write: we=%b stall=%b a=%h d=%h expected we=1 stall=1 a=40 d=a5a5", p_ram_we, p_ram_stall, p_ram_addr, p_ram_wdata);
    else passed++;
    @(negedge clk);
    checks++;
    if ({p_ram_we, p_ram_stall, p_ram_addr} !== {1'b0, 1'b0, 8'h40})
      $display("FAIL poke_release: we=%b stall=%b a=%h expected we=0 stall=0 a=40", p_ram_we, p_ram_stall, p_ram_addr);
    else passed++;
    wait_idle(ok);
    checks++;
    if (!ok || obs.size() != 1 || obs[0] !== wr_t'{1'b1, 8'h40, 16'hA5A5, c + 1})
      $display("FAIL poke_log: idle=%b writes=%0d edge=%0d expected idle=1 writes=1 edge=%0d", ok, obs.size(), obs[0].c, c + 1);
    else passed++;
  endtask

  task automatic test_p_then_v();
    int e0, e1; logic r, ok;
    obs.delete();
    fetch_idle = 1'b1;
    send(1'b1, 8'h41, 16'h5A5A, e0, r);
    send(1'b0, 8'h05, 16'h0001, e1, r);
    wait_idle(ok);
    checks++;
    if (!ok || obs.size() != 2 || e1 != e0 + 1)
      $display("FAIL p_then_v_count: idle=%b writes=%0d gap=%0d expected 1 2 1", ok, obs.size(), e1 - e0);
    else passed++;
    checks++;
    if (obs[0] !== wr_t'{1'b1, 8'h41, 16'h5A5A, e0 + 2})
      $display("FAIL p_then_v_first: t=%b a=%h edge=%0d expected t=1 a=41 edge=%0d", obs[0].t, obs[0].a, obs[0].c, e0 + 2);
    else passed++;
    checks++;
    if (obs[1] !== wr_t'{1'b0, 8'h05, 16'h0001, e0 + 4})
      $display("FAIL p_then_v_second: t=%b a=%h edge=%0d expected t=0 a=05 edge=%0d", obs[1].t, obs[1].a, obs[1].c, e0 + 4);
    else passed++;
  endtask

  task automatic test_full();
    int e; logic r, ok, held_ok;
    obs.delete(); exp_q.delete();
    fetch_idle = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(i == 0, 8'h50 + 8'(i), 16'h1111 * 16'(i + 1), e, r);
      exp_q.push_back(wr_t'{i == 0, 8'h50 + 8'(i), 16'h1111 * 16'(i + 1), e});
    end
    checks++;
    if (in_ready !== 1'b0) $display("FAIL full_ready: in_ready=%b expected 0 after 4 accepted", in_ready);
    else passed++;
    in_valid = 1'b1; in_target = 1'b0; in_addr = 8'h54; in_data = 16'h2222;
    held_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (in_ready) held_ok = 1'b0;
    end
    checks++;
    if (!held_ok) $display("FAIL full_hold: in_ready rose while head poke blocked, expected 0");
    else passed++;
    fetch_idle = 1'b1;
    send(1'b0, 8'h54, 16'h2222, e, r);
    exp_q.push_back(wr_t'{1'b0, 8'h54, 16'h2222, e});
    wait_idle(ok);
    checks++;
    if (!ok || obs.size() != 5) $display("FAIL full_count: idle=%b writes=%0d expected idle=1 writes=5", ok, obs.size());
    else passed++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({obs[i].t, obs[i].a, obs[i].d} !== {exp_q[i].t, exp_q[i].a, exp_q[i].d})
        $display("FAIL full_order%0d: got t=%b a=%h d=%h expected t=%b a=%h d=%h",
                 i, obs[i].t, obs[i].a, obs[i].d, exp_q[i].t, exp_q[i].a, exp_q[i].d);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int e; logic r;
    obs.delete();
    fetch_idle = 1'b0;
    send(1'b1, 8'h60, 16'h3333, e, r);
    send(1'b0, 8'h61, 16'h4444, e, r);
    send(1'b0, 8'h62, 16'h5555, e, r);
    checks++;
    if ({p_ram_stall, pending} !== 2'b11) $display("FAIL rst_mid_pre: stall=%b pend=%b expected 1 1", p_ram_stall, pending);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, pending, v_ram_we, p_ram_we, p_ram_stall, v_ram_addr, v_ram_wdata, p_ram_addr, p_ram_wdata} !== {1'b1, 52'd0})
      $display("FAIL rst_mid_clear: ready=%b pend=%b vwe=%b pwe=%b stall=%b pa=%h pd=%h expected ready=1, rest 0",
               in_ready, pending, v_ram_we, p_ram_we, p_ram_stall, p_ram_addr, p_ram_wdata);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    fetch_idle = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (obs.size() != 0 || pending !== 1'b0) $display("FAIL rst_mid_after: writes=%0d pend=%b expected 0 0", obs.size(), pending);
    else passed++;
  endtask

  task automatic test_random();
    int e, nv, np; logic r, ok, mono;
    obs.delete(); exp_q.delete();
    both_hi = 0; p_bad = 0; stop = 1'b0; nv = 0; np = 0;
    fork
      while (!stop) begin
        @(negedge clk);
        fetch_idle = $urandom_range(0, 2) != 0;
      end
    join_none
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      begin
        logic t; logic [7:0] a; logic [15:0] d;
        t = $urandom_range(0, 3) == 0;
        a = 8'($urandom);
        d = 16'($urandom);
        send(t, a, d, e, r);
        exp_q.push_back(wr_t'{t, a, d, e});
        if (t) np++; else nv++;
      end
    end
    stop = 1'b1;
    repeat (2) @(negedge clk);
    fetch_idle = 1'b1;
    wait_idle(ok);
    checks++;
    if (!ok || obs.size() != exp_q.size()) $display("FAIL rand_count: idle=%b writes=%0d expected idle=1 writes=%0d", ok, obs.size(), exp_q.size());
    else passed++;
    mono = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (obs[i].c <= exp_q[i].c || (i > 0 && obs[i].c <= obs[i-1].c)) mono = 1'b0;
      checks++;
      if ({obs[i].t, obs[i].a, obs[i].d} !== {exp_q[i].t, exp_q[i].a, exp_q[i].d})
        $display("FAIL rand_order%0d: got t=%b a=%h d=%h expected t=%b a=%h d=%h",
                 i, obs[i].t, obs[i].a, obs[i].d, exp_q[i].t, exp_q[i].a, exp_q[i].d);
      else passed++;
    end
    checks++;
    if (!mono) $display("FAIL rand_timing: a write retired before acceptance or two writes shared an edge, expected strictly later");
    else passed++;
    checks++;
    if (both_hi != 0 || p_bad != 0) $display("FAIL rand_strobes: both_high=%0d poke_without_idle_or_stall=%0d expected 0 0", both_hi, p_bad);
    else passed++;
`ifdef STORE_STATS_EN
    checks++;
    if ({v_write_count, p_write_count} !== {16'(nv), 16'(np)})
      $display("FAIL rand_stats: v=%0d p=%0d expected v=%0d p=%0d", v_write_count, p_write_count, nv, np);
    else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_single_v();
    test_v_burst();
    test_p_poke();
    test_p_then_v();
    test_full();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ram_store_controller.md
Name: ram_store_controller

Overview:
- Write-side counterpart of the datapath read routing: accepts store/poke requests from the execute stage and writes them into variable RAM or program RAM.
- Buffers requests in a small in-order FIFO and drains one write per cycle to the target RAM.
- Program-RAM writes are interlocked with instruction fetch through a stall/idle handshake.
- Sits between execute-stage store logic and the RAM write ports.

Parameters:
- WORD_SIZE, 16, data word width (matches RAM word width).
- ADDR_WIDTH, 8, RAM address width; shared by both RAMs.
- FIFO_DEPTH, 4, request buffer entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  store request present.
- in_ready  output  1  request accepted when high with in_valid at a rising edge.
- in_target  input  1  0 = variable RAM store, 1 = program RAM poke.
- in_addr  input  ADDR_WIDTH  write address.
- in_data  input  WORD_SIZE  write data.
- fetch_idle  input  1  fetch unit confirms no program-RAM access this cycle.
- p_ram_stall  output  1  request to halt instruction fetch.
- p_ram_we  output  1  program RAM write strobe.
- p_ram_addr  output  ADDR_WIDTH  program RAM write address.
- p_ram_wdata  output  WORD_SIZE  program RAM write data.
- v_ram_we  output  1  variable RAM write strobe.
- v_ram_addr  output  ADDR_WIDTH  variable RAM write address.
- v_ram_wdata  output  WORD_SIZE  variable RAM write data.
- pending  output  1  FIFO non-empty or a write in flight.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO emptied; FSM enters IDLE.
  - All write strobes, addresses, data and p_ram_stall = 0.
  - in_ready = 1 after reset; pending = 0.
  - Reset mid-operation discards buffered entries; no partial write occurs.
- FIFO push and in_ready:
  - Push on in_valid && in_ready.
  - in_ready = (occupancy < FIFO_DEPTH), taken from registered occupancy. A pop in the same cycle does not raise in_ready combinationally.
  - Simultaneous push and pop when not full: occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Ordering:
  - Writes retire strictly in acceptance order.
  - A program-RAM head entry blocks later variable-RAM entries.
- All RAM-side outputs are registered.
- FSM IDLE:
  - FIFO empty: stay.
  - Head target 0: pop head; register v_ram_we=1 with addr/data for exactly one cycle; stay IDLE. Back-to-back variable stores issue one per cycle.
  - Head target 1: go to P_REQ and register p_ram_stall=1.
- FSM P_REQ:
  - Hold p_ram_stall=1.
  - At an edge with fetch_idle=1: pop head, register p_ram_we=1, go to P_WRITE.
  - fetch_idle=0: wait indefinitely.
- FSM P_WRITE:
  - Next edge: p_ram_we=0, p_ram_stall=0, go to IDLE.
  - IDLE then evaluates the new head on the following edge, so there is one turnaround cycle between consecutive program-RAM writes.
- Latency:
  - Push at edge E with the FIFO empty and target 0 gives v_ram_we high from E+1 to E+2.
  - Target 1 gives p_ram_stall high from E+1. p_ram_we rises at the first edge at or after E+2 where fetch_idle=1 was sampled.
- Strobe exclusivity: v_ram_we and p_ram_we are never high together; each strobe is high for exactly one cycle per write.
- Addr/data outputs hold their last value when the strobe is low.
- pending = occupancy != 0 OR state != IDLE OR any strobe high.

Optional Feature:
- Macro: STORE_STATS_EN.
- When defined, adds outputs:
  - p_write_count (16 bits): saturating count of p_ram_we pulses.
  - v_write_count (16 bits): saturating count of v_ram_we pulses.
  - stall_cycles (16 bits): saturating count of cycles in P_REQ with fetch_idle=0.
  - All three reset to 0 and saturate at 0xFFFF.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then a single v store (addr 0x12, data 0xBEEF) -> v_ram_we high exactly one cycle, 1 cycle after the push edge, with addr 0x12 and data 0xBEEF; p_ram_we stays 0.
- 4 v stores in consecutive cycles, addr 0x00–0x03, data 0x1000–0x1003 -> four consecutive v_ram_we pulses in order; in_ready never drops when FIFO_DEPTH=4.
- P poke (addr 0x40, data 0xA5A5) with fetch_idle held 0 for 5 cycles, then 1 -> p_ram_stall high for the whole wait; p_ram_we high one cycle after fetch_idle is sampled high; stall drops the following cycle.
- P poke followed by v store (0x05, 0x0001) -> the v write occurs only after p_ram_we, with one turnaround cycle; order is preserved.
- Hold fetch_idle=0 and push 5 requests -> in_ready=0 after 4 accepted; the 5th is held until a pop; no entry is lost or duplicated.
- Assert rst_n=0 while in P_REQ with 3 entries buffered -> all outputs clear immediately; after release, no writes are issued and pending=0.
